// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   BAUD_W     : width of the bit-time counter and of the k / k_div2 inputs
//   SR_W       : width of the receive shift register (start excluded, up to 8 data + parity + stop)
//   rx_state_t : receive FSM state encoding
//   frame_len  : number of post-start samples for the configured frame format
package uart_pkg;

    localparam int BAUD_W = 20;
    localparam int SR_W   = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2
    } rx_state_t;

    // 7 data bits + optional 8th bit + optional parity + stop
    function automatic logic [3:0] frame_len(input logic eight, input logic pen);
        return 4'd8 + {3'b000, eight} + {3'b000, pen};
    endfunction

endpackage

// File: rtl/uart_rx_shift_reg.sv
// Receive shift register. Each sh pulse shifts din into the MSB and moves
// everything one place towards the LSB, so the first bit received ends up
// lowest once the frame is complete.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   sh    : shift enable (one cycle per sampled bit)
//   clr   : synchronous clear at the start of a frame
//   din   : synchronised serial bit
//   q     : register contents
module uart_rx_shift_reg
    import uart_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            sh,
    input  logic            clr,
    input  logic            din,
    output logic [SR_W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (sh) begin
            q <= {din, q[SR_W-1:1]};
        end
    end

endmodule

// File: rtl/uart_receive.sv
// UART receive engine: start-bit detection, mid-bit sampling, frame
// assembly and processor-visible status.
//   clk, reset      : system clock, asynchronous active-low reset
//   k, k_div2       : bit time and half bit time in clk cycles
//   Rx              : serial input, idle high
//   port_id         : bus address, not decoded here
//   reads           : decoded read strobes; reads[0] reads data/status
//   ohel, eight, pen: parity sense (1 = odd), 8-bit mode, parity enable
//   data            : received byte
//   perror, ferror, oerror : sticky parity / framing / overrun flags
//   RxRdy           : new frame available, cleared by reads[0]
//
// state | meaning
// IDLE  | waiting for Rx low
// START | timing half a bit to confirm the start bit at its centre
// DATA  | sampling data/parity/stop bits every k cycles
module uart_receive
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [BAUD_W-1:0] k,
    input  logic [BAUD_W-1:0] k_div2,
    input  logic              Rx,
    input  logic [15:0]       port_id,
    input  logic [15:0]       reads,
    input  logic              ohel,
    input  logic              eight,
    input  logic              pen,
    output logic [7:0]        data,
    output logic              perror,
    output logic              ferror,
    output logic              oerror,
    output logic              RxRdy
);

    rx_state_t         state, state_next;
    logic              rx_meta, rx_sync;
    logic [BAUD_W-1:0] baud_cnt, baud_cnt_next;
    logic [3:0]        bit_cnt, bit_cnt_next;
    logic              sh, done, sr_clr;
    logic [SR_W-1:0]   sr_q, aligned;
    logic [3:0]        n_bits, par_idx, stop_idx;
    logic [7:0]        data_bits;
    logic              parity_bit, stop_bit;

    // Bus fields this block does not decode.
    logic unused_bus;
    assign unused_bus = ^{port_id, reads[15:1]};

    // Synchroniser resets to the idle line level so release from reset
    // cannot look like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_sync <= rx_meta;
        end
    end

    assign n_bits = frame_len(eight, pen);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_cnt  <= bit_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt + BAUD_W'(1);
        bit_cnt_next  = bit_cnt;
        sh            = 1'b0;
        done          = 1'b0;
        sr_clr        = 1'b0;
        case (state)
            IDLE: begin
                baud_cnt_next = '0;
                if (!rx_sync) state_next = START;
            end
            START: begin
                if (baud_cnt == k_div2 - BAUD_W'(1)) begin
                    baud_cnt_next = '0;
                    if (!rx_sync) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                        sr_clr       = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                // done comes the cycle after the stop-bit shift so the
                // shift register already holds the whole frame.
                if (bit_cnt == n_bits) begin
                    done          = 1'b1;
                    state_next    = IDLE;
                    baud_cnt_next = '0;
                end else if (baud_cnt == k - BAUD_W'(1)) begin
                    sh            = 1'b1;
                    baud_cnt_next = '0;
                    bit_cnt_next  = bit_cnt + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    uart_rx_shift_reg sr (
        .clk   (clk),
        .reset (reset),
        .sh    (sh),
        .clr   (sr_clr),
        .din   (rx_sync),
        .q     (sr_q)
    );

    // Short frames leave the first bit above position 0; right-justify it.
    assign aligned    = sr_q >> (4'(SR_W) - n_bits);
    assign stop_idx   = n_bits - 4'd1;
    assign par_idx    = n_bits - 4'd2;
    assign stop_bit   = aligned[stop_idx];
    assign parity_bit = aligned[par_idx];
    assign data_bits  = eight ? aligned[7:0] : {1'b0, aligned[6:0]};

    // A completing frame takes priority over a simultaneous read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data   <= '0;
            perror <= 1'b0;
            ferror <= 1'b0;
            oerror <= 1'b0;
            RxRdy  <= 1'b0;
        end else if (done) begin
            data   <= data_bits;
            ferror <= ~stop_bit;
            perror <= pen & ((^data_bits ^ parity_bit) != ohel);
            oerror <= RxRdy;
            RxRdy  <= 1'b1;
        end else if (reads[0]) begin
            perror <= 1'b0;
            ferror <= 1'b0;
            oerror <= 1'b0;
            RxRdy  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive with an expected-frame scoreboard.
module tb_uart_receive;
    import uart_pkg::*;

    localparam int K  = 109;
    localparam int KH = 55;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] k, k_div2;
    logic        Rx;
    logic [15:0] port_id, reads;
    logic        ohel, eight, pen;
    logic [7:0]  data;
    logic        perror, ferror, oerror, RxRdy;

    typedef struct {
        logic [7:0] data;
        logic       perror;
        logic       ferror;
        logic       oerror;
    } exp_t;

    exp_t sb[$];
    int   sh_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   model_rdy = 1'b0;

    uart_receive dut (
        .clk     (clk),
        .reset   (reset),
        .k       (k),
        .k_div2  (k_div2),
        .Rx      (Rx),
        .port_id (port_id),
        .reads   (reads),
        .ohel    (ohel),
        .eight   (eight),
        .pen     (pen),
        .data    (data),
        .perror  (perror),
        .ferror  (ferror),
        .oerror  (oerror),
        .RxRdy   (RxRdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Records the cycle of every sample pulse.
    initial begin : sh_mon
        forever begin
            @(negedge clk);
            if (dut.sh === 1'b1) sh_q.push_back(cyc);
        end
    end

    // On every frame completion, compare the registered result one cycle later.
    initial begin : sb_mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (dut.done === 1'b1) begin
                @(negedge clk);
                check("sb_frame_expected", 8'(sb.size() != 0), 8'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("frame_data",   data,            e.data);
                    check("frame_perror", {7'd0, perror},  {7'd0, e.perror});
                    check("frame_ferror", {7'd0, ferror},  {7'd0, e.ferror});
                    check("frame_oerror", {7'd0, oerror},  {7'd0, e.oerror});
                    check("frame_rxrdy",  {7'd0, RxRdy},   8'd1);
                end
            end
        end
    end

    task automatic push_frame(input logic [7:0] v, input bit e8, input bit pe,
                              input bit par, input bit stp);
        exp_t       m;
        logic [7:0] d;
        d        = e8 ? v : {1'b0, v[6:0]};
        m.data   = d;
        m.ferror = ~stp;
        m.perror = pe && ((^d ^ par) != ohel);
        m.oerror = model_rdy;
        model_rdy = 1'b1;
        sb.push_back(m);
    endtask

    task automatic bit_time(input logic b);
        Rx = b;
        repeat (K) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] v, input bit e8, input bit pe,
                              input bit par, input bit stp);
        bit_time(1'b0);
        for (int i = 0; i < (e8 ? 8 : 7); i++) bit_time(v[i]);
        if (pe) bit_time(par);
        bit_time(stp);
        Rx = 1'b1;
    endtask

    task automatic idle(input int n);
        Rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_read();
        @(negedge clk);
        reads = 16'h0001;
        @(negedge clk);
        reads = 16'h0000;
        model_rdy = 1'b0;
    endtask

    initial begin : stim
        int gap_bad;
        reset = 1'b0; Rx = 1'b1; k = 20'(K); k_div2 = 20'(KH);
        port_id = 16'h0040; reads = 16'h0000;
        ohel = 1'b1; eight = 1'b1; pen = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data",   data,           8'h00);
        check("rst_perror", {7'd0, perror}, 8'd0);
        check("rst_ferror", {7'd0, ferror}, 8'd0);
        check("rst_oerror", {7'd0, oerror}, 8'd0);
        check("rst_rxrdy",  {7'd0, RxRdy},  8'd0);
        reset = 1'b1;
        idle(10);

        // 8 data, odd parity, good frame; sample pulses one bit time apart
        sh_q.delete();
        push_frame(8'h99, 1, 1, 1, 1);
        send_frame(8'h99, 1, 1, 1, 1);
        idle(K);
        check("f1_sh_count", 8'(sh_q.size()), 8'd10);
        gap_bad = 0;
        for (int i = 1; i < sh_q.size(); i++)
            if (sh_q[i] - sh_q[i-1] != K) gap_bad++;
        check("f1_sh_spacing", 8'(gap_bad), 8'd0);
        do_read();
        check("f1_read_rxrdy", {7'd0, RxRdy}, 8'd0);
        check("f1_read_data",  data,          8'h99);

        // wrong parity under odd sense, then the same bit under even sense
        push_frame(8'h99, 1, 1, 0, 1);
        send_frame(8'h99, 1, 1, 0, 1);
        idle(K);
        do_read();
        check("p_read_perror", {7'd0, perror}, 8'd0);
        ohel = 1'b0;
        push_frame(8'h99, 1, 1, 0, 1);
        send_frame(8'h99, 1, 1, 0, 1);
        idle(K);
        do_read();

        // 7-bit, no parity, stop bit low
        eight = 1'b0; pen = 1'b0;
        push_frame(8'h55, 0, 0, 0, 0);
        send_frame(8'h55, 0, 0, 0, 0);
        idle(K);
        do_read();
        check("fe_read_rxrdy",  {7'd0, RxRdy},  8'd0);
        check("fe_read_ferror", {7'd0, ferror}, 8'd0);
        check("fe_read_data",   data,           8'h55);

        // short low glitch must be rejected as a false start
        sh_q.delete();
        Rx = 1'b0;
        repeat (20) @(negedge clk);
        idle(200);
        check("glitch_sh_count", 8'(sh_q.size()), 8'd0);
        check("glitch_rxrdy",    {7'd0, RxRdy},  8'd0);
        check("glitch_state",    {6'd0, dut.state}, {6'd0, IDLE});

        // back-to-back frames without a read: overrun on the second
        eight = 1'b1; pen = 1'b0; ohel = 1'b1;
        push_frame(8'hA5, 1, 0, 0, 1);
        send_frame(8'hA5, 1, 0, 0, 1);
        push_frame(8'h3C, 1, 0, 0, 1);
        send_frame(8'h3C, 1, 0, 0, 1);
        idle(K);
        check("ovr_data", data, 8'h3C);
        do_read();
        check("ovr_read_oerror", {7'd0, oerror}, 8'd0);

        // leave a frame pending, then reset in the middle of the next one
        pen = 1'b1;
        push_frame(8'h6B, 1, 1, 0, 1);
        send_frame(8'h6B, 1, 1, 0, 1);
        idle(K);
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b1);
        Rx = 1'b0;
        repeat (40) @(negedge clk);
        reset = 1'b0;
        Rx = 1'b1;
        #1;
        check("mid_rst_data",   data,           8'h00);
        check("mid_rst_perror", {7'd0, perror}, 8'd0);
        check("mid_rst_ferror", {7'd0, ferror}, 8'd0);
        check("mid_rst_oerror", {7'd0, oerror}, 8'd0);
        check("mid_rst_rxrdy",  {7'd0, RxRdy},  8'd0);
        check("mid_rst_state",  {6'd0, dut.state}, {6'd0, IDLE});
        model_rdy = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        idle(20);

        // 7-bit with parity: parity lands in bit 7 of the aligned word and must be masked
        eight = 1'b0;
        push_frame(8'h4D, 0, 1, 1, 1);
        send_frame(8'h4D, 0, 1, 1, 1);
        idle(K);
        do_read();

        check("sb_drained", 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
